mul_issue_ctrl: RTL

Issue/writeback controller sitting directly upstream and downstream of the multiplier wrapper (the shared-operand multiplier with inready/invalid/outvalid/flush handshake).
- Accepts RISC-V M-extension multiply requests (MUL/MULH/MULHSU/MULHU) from the execute pipeline.
- Decodes the op into the multiplier's mul_signed control and drives the operands.
- Captures the one-cycle result pulse into a holding register and presents the selected 32-bit word to writeback through a valid/ready handshake.
- Handles pipeline flush at any point of an operation.

---
 rtl/mul_issue_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback controller for the shared-operand multiplier: accepts RV32M multiply ops, issues them, and returns the selected result word.
// Optional build macro: MUL_ZERO_BYPASS_EN (zero operand skips the multiplier and completes with 0).
module mul_issue_ctrl #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [XLEN-1:0]  req_rs1,
    input  logic [XLEN-1:0]  req_rs2,
    input  logic [TAG_W-1:0] req_rd,
    input  logic             flush,
    input  logic             mul_inready,
    output logic             mul_invalid,
    output logic             mul_flush,
    output logic [1:0]       mul_signed,
    output logic [XLEN-1:0]  mul_multiplicand,
    output logic [XLEN-1:0]  mul_multiplier,
    input  logic             mul_outvalid,
    input  logic [XLEN-1:0]  mul_result_hi,
    input  logic [XLEN-1:0]  mul_result_lo,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [TAG_W-1:0] wb_rd,
    output logic [XLEN-1:0]  wb_data
);

    typedef enum logic [2:0] {IDLE, ISSUE, BUSY, DRAIN, DONE} state_t;

    state_t           state;
    state_t           state_nx;
    logic [XLEN-1:0]  rs1_q;
    logic [XLEN-1:0]  rs2_q;
    logic [XLEN-1:0]  data_q;
    logic [TAG_W-1:0] rd_q;
    logic [1:0]       op_q;
    logic [1:0]       sgn_q;
    logic [1:0]       sgn_dec;
    logic             drain_flush_q;
    logic             accept;
    logic             bypass;

    assign req_ready = (state == IDLE) && !flush && !rst;
    assign accept    = req_valid && req_ready;

`ifdef MUL_ZERO_BYPASS_EN
    assign bypass = (req_rs1 == '0) || (req_rs2 == '0);
`else
    assign bypass = 1'b0;
`endif

    always_comb begin
        case (req_op)
            2'b00, 2'b01: sgn_dec = 2'b11;
            2'b10:        sgn_dec = 2'b10;
            default:      sgn_dec = 2'b00;
        endcase
    end

    always_comb begin
        state_nx    = state;
        mul_invalid = 1'b0;
        mul_flush   = 1'b0;
        wb_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nx = bypass ? DONE : ISSUE;
            end
            ISSUE: begin
                mul_invalid = 1'b1;
                // A flush in the same cycle the multiplier takes the op still has to cancel it there.
                if (flush)            state_nx = mul_inready ? DRAIN : IDLE;
                else if (mul_inready) state_nx = BUSY;
            end
            BUSY: begin
                if (flush) begin
                    mul_flush = 1'b1;
                    state_nx  = DRAIN;
                end else if (mul_outvalid) begin
                    state_nx = DONE;
                end
            end
            DRAIN: begin
                mul_flush = drain_flush_q;
                if (mul_inready) state_nx = IDLE;
            end
            DONE: begin
                wb_valid = 1'b1;
                if (flush || wb_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Signedness is decoded once at accept and stored, which equals decoding the stored op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rs1_q         <= '0;
            rs2_q         <= '0;
            rd_q          <= '0;
            op_q          <= '0;
            sgn_q         <= '0;
            data_q        <= '0;
            drain_flush_q <= 1'b0;
        end else begin
            state         <= state_nx;
            drain_flush_q <= (state == ISSUE) && flush && mul_inready;
            if (accept) begin
                rs1_q <= req_rs1;
                rs2_q <= req_rs2;
                rd_q  <= req_rd;
                op_q  <= req_op;
                sgn_q <= sgn_dec;
                if (bypass) data_q <= '0;
            end
            if ((state == BUSY) && !flush && mul_outvalid)
                data_q <= (op_q == 2'b00) ? mul_result_lo : mul_result_hi;
        end
    end

    assign mul_signed       = sgn_q;
    assign mul_multiplicand = rs1_q;
    assign mul_multiplier   = rs2_q;
    assign wb_rd            = rd_q;
    assign wb_data          = data_q;

endmodule
